// File: rtl/up_byte_bridge_if.sv
// Bundles the uP byte port and the register-file port of up_byte_bridge.
// Handshake: the uP raises uP_start with uP_data_in stable and waits for uP_ack;
// it then drops uP_start and waits for uP_ack to fall. reg_wr/reg_rd are
// single-cycle strobes, and reg_rd_valid qualifies reg_rd_data for one cycle.
interface up_byte_bridge_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 8
);
  logic                    uP_start;
  logic                    uP_RW;
  logic [7:0]              uP_data_in;
  logic [7:0]              uP_data_out;
  logic                    uP_data_oe;
  logic                    uP_ack;
  logic [ADDR_WIDTH-1:0]   reg_address;
  logic [8*DATA_BYTES-1:0] reg_wr_data;
  logic                    reg_wr;
  logic                    reg_rd;
  logic [8*DATA_BYTES-1:0] reg_rd_data;
  logic                    reg_rd_valid;
  logic                    timeout_err;
  logic                    busy;
  logic [3:0]              state_dbg;

  modport slave (
    input  uP_start, uP_RW, uP_data_in, reg_rd_data, reg_rd_valid,
    output uP_data_out, uP_data_oe, uP_ack, reg_address, reg_wr_data,
           reg_wr, reg_rd, timeout_err, busy, state_dbg
  );

  modport master (
    output uP_start, uP_RW, uP_data_in, reg_rd_data, reg_rd_valid,
    input  uP_data_out, uP_data_oe, uP_ack, reg_address, reg_wr_data,
           reg_wr, reg_rd, timeout_err, busy, state_dbg
  );
endinterface

// File: rtl/up_byte_bridge.sv
// Bridges an asynchronous byte-wide uP strobe/ack port to a word-wide register
// file, with a per-handshake-edge watchdog that aborts stalled transactions.
module up_byte_bridge #(
  parameter int DATA_BYTES     = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             reset,
  up_byte_bridge_if.slave  bus
);

  localparam int W     = 8 * DATA_BYTES;
  localparam int CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(DATA_BYTES - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ADDR_ACK   = 4'd1,
    WR_WAIT    = 4'd2,
    WR_ACK     = 4'd3,
    WR_COMMIT  = 4'd4,
    RD_REQ     = 4'd5,
    RD_WAIT    = 4'd6,
    RD_PRESENT = 4'd7,
    RD_ACK     = 4'd8
  } state_t;

  state_t state, state_next;

  logic                  start_q1, start_s, rw_q1, rw_s, rw_lat;
  logic [CNT_W-1:0]      byte_cnt;
  logic [WD_W-1:0]       wd_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [W-1:0]          wr_data_q, shadow_q;
  logic [7:0]            data_out_q, lane_out;
  logic                  ack_q, oe_q, wr_q, rd_q, to_err_q;

  logic lat_addr, wr_lane, inc_cnt, lat_shadow, load_out, timeout;
  logic last_lane, watched, wd_hit;

  assign last_lane = (byte_cnt == LAST_LANE);
  assign watched   = (state != IDLE) && (state != WR_COMMIT);
  assign wd_hit    = watched && (wd_cnt == WD_LAST);

  always_comb begin
    lane_out = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (byte_cnt == CNT_W'(i)) lane_out = shadow_q[i*8 +: 8];
    end
  end

  always_comb begin
    state_next = state;
    lat_addr   = 1'b0;
    wr_lane    = 1'b0;
    inc_cnt    = 1'b0;
    lat_shadow = 1'b0;
    load_out   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: if (start_s) begin
        lat_addr   = 1'b1;
        state_next = ADDR_ACK;
      end
      ADDR_ACK: if (!start_s) state_next = rw_lat ? RD_REQ : WR_WAIT;
      WR_WAIT: if (start_s) begin
        wr_lane    = 1'b1;
        state_next = WR_ACK;
      end
      WR_ACK: if (!start_s) begin
        inc_cnt    = !last_lane;
        state_next = last_lane ? WR_COMMIT : WR_WAIT;
      end
      WR_COMMIT: state_next = IDLE;
      RD_REQ:    state_next = RD_WAIT;
      RD_WAIT: if (bus.reg_rd_valid) begin
        lat_shadow = 1'b1;
        state_next = RD_PRESENT;
      end
      RD_PRESENT: if (start_s) begin
        load_out   = 1'b1;
        state_next = RD_ACK;
      end
      RD_ACK: if (!start_s) begin
        inc_cnt    = !last_lane;
        state_next = last_lane ? IDLE : RD_PRESENT;
      end
      default: state_next = IDLE;
    endcase
    // The watchdog overrides any progress made in the same cycle.
    if (wd_hit) begin
      state_next = IDLE;
      timeout    = 1'b1;
      wr_lane    = 1'b0;
      inc_cnt    = 1'b0;
      lat_shadow = 1'b0;
      load_out   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      start_q1   <= 1'b0;
      start_s    <= 1'b0;
      rw_q1      <= 1'b0;
      rw_s       <= 1'b0;
      rw_lat     <= 1'b0;
      byte_cnt   <= '0;
      wd_cnt     <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      shadow_q   <= '0;
      data_out_q <= '0;
      ack_q      <= 1'b0;
      oe_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      start_q1 <= bus.uP_start;
      start_s  <= start_q1;
      rw_q1    <= bus.uP_RW;
      rw_s     <= rw_q1;
      state    <= state_next;

      if (state_next != state) wd_cnt <= '0;
      else if (watched)        wd_cnt <= wd_cnt + 1'b1;

      if (lat_addr) begin
        addr_q   <= bus.uP_data_in[ADDR_WIDTH-1:0];
        rw_lat   <= rw_s;
        byte_cnt <= '0;
        to_err_q <= 1'b0;
      end
      if (timeout) to_err_q <= 1'b1;
      if (inc_cnt) byte_cnt <= byte_cnt + 1'b1;

      if (wr_lane) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          if (byte_cnt == CNT_W'(i)) wr_data_q[i*8 +: 8] <= bus.uP_data_in;
        end
      end
      if (lat_shadow) shadow_q   <= bus.reg_rd_data;
      if (load_out)   data_out_q <= lane_out;

      // Read ack trails the RD_ACK entry by one clock so data and oe lead it.
      ack_q <= (state_next == ADDR_ACK) || (state_next == WR_ACK) ||
               ((state == RD_ACK) && (state_next == RD_ACK));
      oe_q  <= (state_next == RD_ACK);
      wr_q  <= (state_next == WR_COMMIT);
      rd_q  <= (state_next == RD_REQ);
    end
  end

  assign bus.uP_data_out = data_out_q;
  assign bus.uP_data_oe  = oe_q;
  assign bus.uP_ack      = ack_q;
  assign bus.reg_address = addr_q;
  assign bus.reg_wr_data = wr_data_q;
  assign bus.reg_wr      = wr_q;
  assign bus.reg_rd      = rd_q;
  assign bus.timeout_err = to_err_q;
  assign bus.busy        = (state != IDLE);
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_up_byte_bridge.sv
// Bench for up_byte_bridge: a 4-byte instance exercised with directed and random
// transactions against a register-file model, plus a 1-byte/4-bit-address instance.
module tb_up_byte_bridge;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  up_byte_bridge_if #(.DATA_BYTES(4), .ADDR_WIDTH(8)) bus0 ();
  up_byte_bridge_if #(.DATA_BYTES(1), .ADDR_WIDTH(4)) bus1 ();

  up_byte_bridge #(.DATA_BYTES(4), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  up_byte_bridge #(.DATA_BYTES(1), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  logic        up_start = 1'b0;
  logic        up_rw    = 1'b0;
  logic [7:0]  up_data  = 8'h00;
  logic        sel      = 1'b0;
  logic [31:0] rd_data0 = 32'h0;
  logic        rd_valid0 = 1'b0;
  logic        rd_en    = 1'b1;
  int          rd_lat   = 3;

  assign bus0.uP_start     = up_start & ~sel;
  assign bus1.uP_start     = up_start & sel;
  assign bus0.uP_RW        = up_rw;
  assign bus1.uP_RW        = up_rw;
  assign bus0.uP_data_in   = up_data;
  assign bus1.uP_data_in   = up_data;
  assign bus0.reg_rd_data  = rd_data0;
  assign bus0.reg_rd_valid = rd_valid0;
  assign bus1.reg_rd_data  = 8'h00;
  assign bus1.reg_rd_valid = 1'b0;

  logic       ack_m, oe_m;
  logic [7:0] dout_m;
  assign ack_m  = sel ? bus1.uP_ack      : bus0.uP_ack;
  assign oe_m   = sel ? bus1.uP_data_oe  : bus0.uP_data_oe;
  assign dout_m = sel ? bus1.uP_data_out : bus0.uP_data_out;

  logic [53:0] outs0;
  assign outs0 = {bus0.uP_ack, bus0.uP_data_oe, bus0.reg_wr, bus0.reg_rd,
                  bus0.timeout_err, bus0.busy, bus0.reg_address,
                  bus0.reg_wr_data, bus0.uP_data_out};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-file model and expected-write scoreboard ({addr, data}).
  logic [31:0] mem [256];
  logic [39:0] exp_q [$];
  logic [39:0] mon_e;
  int wr_cnt0 = 0;
  int rd_cnt0 = 0;
  int wr_cnt1 = 0;

  always @(negedge clk) begin
    if (bus0.reg_wr) begin
      wr_cnt0++;
      check("wr_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_word", {bus0.reg_address, bus0.reg_wr_data}, mon_e);
      end
    end
    if (bus0.reg_rd) rd_cnt0++;
    if (bus1.reg_wr) wr_cnt1++;
  end

  // Register-file responder: returns mem[address] rd_lat cycles after reg_rd.
  logic [7:0] resp_a;
  initial begin
    forever begin
      @(negedge clk);
      if (bus0.reg_rd && rd_en) begin
        resp_a = bus0.reg_address;
        repeat (rd_lat) @(negedge clk);
        rd_data0  = mem[resp_a];
        rd_valid0 = 1'b1;
        @(negedge clk);
        rd_valid0 = 1'b0;
        rd_data0  = $urandom;
      end
    end
  end

  task automatic up_cycle(input logic [7:0] b, input logic rw, input logic rd_byte,
                          output logic [7:0] rdb);
    int n;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    up_data  = b;
    up_rw    = rw;
    up_start = 1'b1;
    n = 0;
    while (!ack_m && n < 64) begin @(negedge clk); n++; end
    check("ack_rise_bound", n < 64, 1'b1);
    rdb = dout_m;
    if (rd_byte) check("oe_with_ack", oe_m, 1'b1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    up_start = 1'b0;
    up_data  = $urandom;
    up_rw    = 1'($urandom);
    n = 0;
    while (ack_m && n < 64) begin @(negedge clk); n++; end
    check("ack_fall_bound", n < 64, 1'b1);
    if (rd_byte) check("oe_after_ack", oe_m, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input int nsend);
    logic [7:0] d;
    if (nsend == 4) begin
      exp_q.push_back({addr, data});
      mem[addr] = data;
    end
    up_cycle(addr, 1'b0, 1'b0, d);
    for (int i = 0; i < nsend; i++) up_cycle(data[i*8 +: 8], 1'($urandom), 1'b0, d);
  endtask

  task automatic do_read(input logic [7:0] addr);
    logic [7:0]  d;
    logic [31:0] w;
    w = mem[addr];
    up_cycle(addr, 1'b1, 1'b0, d);
    for (int i = 0; i < 4; i++) begin
      up_cycle(8'($urandom), 1'($urandom), 1'b1, d);
      check($sformatf("rd_byte%0d", i), d, w[i*8 +: 8]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int exp_wr, exp_rd, n;
    logic [7:0]  a, d;
    logic [31:0] w;
    exp_wr = 0;
    exp_rd = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_outs", outs0, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed write and read
    do_write(8'h12, 32'h11223344, 4); exp_wr++;
    repeat (2) @(negedge clk);
    check("wr_addr_held", bus0.reg_address, 8'h12);
    check("wr_data_held", bus0.reg_wr_data, 32'h11223344);
    mem[8'h05] = 32'hDEADBEEF;
    rd_lat = 3;
    do_read(8'h05); exp_rd++;
    check("rd_busy_end", bus0.busy, 1'b0);

    // Random traffic
    for (int t = 0; t < 16; t++) begin
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, 4); exp_wr++;
      end else begin
        rd_lat = $urandom_range(1, 8);
        do_read(a); exp_rd++;
      end
    end
    check("wr_count_rand", wr_cnt0, exp_wr);
    check("rd_count_rand", rd_cnt0, exp_rd);

    // Write stall after two data bytes
    do_write(8'h33, $urandom, 2);
    n = 0;
    while (bus0.busy && n < 24) begin @(negedge clk); n++; end
    check("wr_stall_within", n <= TO, 1'b1);
    check("wr_stall_err", bus0.timeout_err, 1'b1);
    check("wr_stall_ack", bus0.uP_ack, 1'b0);
    check("wr_stall_no_wr", wr_cnt0, exp_wr);
    up_cycle(8'h34, 1'b0, 1'b0, d);
    check("err_cleared", bus0.timeout_err, 1'b0);
    w = $urandom;
    exp_q.push_back({8'h34, w});
    mem[8'h34] = w;
    for (int i = 0; i < 4; i++) up_cycle(w[i*8 +: 8], 1'($urandom), 1'b0, d);
    exp_wr++;

    // Read stall: no reg_rd_valid
    rd_en = 1'b0;
    up_cycle(8'h40, 1'b1, 1'b0, d); exp_rd++;
    n = 0;
    while (bus0.busy && n < 24) begin @(negedge clk); n++; end
    check("rd_stall_err", bus0.timeout_err, 1'b1);
    check("rd_stall_ack", bus0.uP_ack, 1'b0);
    check("rd_stall_oe", bus0.uP_data_oe, 1'b0);
    check("rd_stall_idle", bus0.busy, 1'b0);
    rd_en = 1'b1;

    // Reset during the third write byte
    do_write(8'h55, 32'hCAFEF00D, 2);
    up_data  = 8'hFE;
    up_start = 1'b1;
    repeat (4) @(negedge clk);
    check("ack_third_byte", bus0.uP_ack, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", outs0, '0);
    reset    = 1'b0;
    up_start = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_no_wr", wr_cnt0, exp_wr);
    check("rst_no_rd", rd_cnt0, exp_rd);
    do_write(8'h56, 32'h0BADC0DE, 4); exp_wr++;
    rd_lat = $urandom_range(1, 8);
    do_read(8'h56); exp_rd++;

    // Single-byte instance, 4-bit address
    sel = 1'b1;
    up_cycle(8'hF7, 1'b0, 1'b0, d);
    up_cycle(8'hA5, 1'($urandom), 1'b0, d);
    repeat (4) @(negedge clk);
    sel = 1'b0;
    check("db1_wr_count", wr_cnt1, 1);
    check("db1_addr", bus1.reg_address, 4'h7);
    check("db1_data", bus1.reg_wr_data, 8'hA5);

    repeat (4) @(negedge clk);
    check("wr_count_final", wr_cnt0, exp_wr);
    check("rd_count_final", rd_cnt0, exp_rd);
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
